// File: rtl/i2s_frame_capture.sv
// I2S receiver: oversamples bck/ws/d0, deserialises MSB-first words and pairs L/R onto a valid/ready sink.
// Optional peak meters (peak_clr, peak_l, peak_r) are built when I2S_CAPTURE_PEAK_EN is defined.
module i2s_frame_capture #(
    parameter int WIDTH    = 24,
    parameter int MIN_BITS = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk_in,
    input  logic             resetb,
    input  logic             i2s_bck,
    input  logic             i2s_ws,
    input  logic             i2s_d0,
    input  logic             sample_ready,
`ifdef I2S_CAPTURE_PEAK_EN
    input  logic             peak_clr,
    output logic [WIDTH-2:0] peak_l,
    output logic [WIDTH-2:0] peak_r,
`endif
    output logic             sample_valid,
    output logic [WIDTH-1:0] sample_l,
    output logic [WIDTH-1:0] sample_r,
    output logic             locked,
    output logic             overflow,
    output logic             short_err
);

    typedef enum logic [1:0] {HUNT, WAIT_L, WAIT_R} state_t;

    localparam logic [5:0]       MIN_CNT = 6'(MIN_BITS);
    localparam logic [7:0]       TMO_MAX = 8'(TIMEOUT);
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    // bit 0 = bck, bit 1 = ws, bit 2 = d0
    logic [2:0]       sync1_q, sync2_q;
    logic             bck_hist_q;
    logic [7:0]       tmo_q;

    state_t           state_q;
    logic             ws_prev_q;
    logic [5:0]       cnt_q;
    logic [5:0]       cnt_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] left_hold_q;
    logic             valid_q;
    logic [WIDTH-1:0] sample_l_q, sample_r_q;
    logic             locked_q, overflow_q, short_q;

    logic             rise, ws_s, d0_s, timeout, boundary;
    logic             word_done, word_short, pair_ev, load;

    assign rise       = sync2_q[0] & ~bck_hist_q;
    assign ws_s       = sync2_q[1];
    assign d0_s       = sync2_q[2];
    assign timeout    = (tmo_q == TMO_MAX);
    assign boundary   = rise & (ws_s != ws_prev_q);
    assign word_done  = boundary & ~timeout & (state_q != HUNT);
    assign word_short = (cnt_q < MIN_CNT);
    assign pair_ev    = word_done & ~word_short & ws_prev_q & (state_q == WAIT_R);
    assign load       = pair_ev & (~valid_q | sample_ready);

    // The shifted mask becomes zero once cnt reaches WIDTH, so surplus bits fall away.
    assign shreg_d = d0_s ? (shreg_q | (MSB_ONE >> cnt_q)) : shreg_q;
    assign cnt_d   = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            bck_hist_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            sync1_q    <= {i2s_d0, i2s_ws, i2s_bck};
            sync2_q    <= sync1_q;
            bck_hist_q <= sync2_q[0];
            if (rise)
                tmo_q <= '0;
            else if (!timeout)
                tmo_q <= tmo_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_q     <= HUNT;
            ws_prev_q   <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            valid_q     <= 1'b0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            locked_q    <= 1'b0;
            overflow_q  <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
            if (rise)
                ws_prev_q <= ws_s;

            if (timeout) begin
                state_q     <= HUNT;
                locked_q    <= 1'b0;
                cnt_q       <= '0;
                shreg_q     <= '0;
                left_hold_q <= '0;
            end else if (boundary) begin
                // The boundary bit is the MSB of the next word.
                shreg_q <= d0_s ? MSB_ONE : '0;
                cnt_q   <= 6'd1;
                case (state_q)
                    HUNT: state_q <= WAIT_L;
                    WAIT_L: begin
                        if (word_short) begin
                            short_q <= 1'b1;
                        end else if (!ws_prev_q) begin
                            left_hold_q <= shreg_q;
                            state_q     <= WAIT_R;
                        end
                    end
                    WAIT_R: begin
                        if (word_short) begin
                            short_q <= 1'b1;
                            state_q <= WAIT_L;
                        end else if (ws_prev_q) begin
                            state_q <= WAIT_L;
                        end else begin
                            left_hold_q <= shreg_q;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end else if (rise) begin
                shreg_q <= shreg_d;
                cnt_q   <= cnt_d;
            end

            if (load) begin
                sample_l_q <= left_hold_q;
                sample_r_q <= shreg_q;
                valid_q    <= 1'b1;
            end else if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end
            if (pair_ev && !load)
                overflow_q <= 1'b1;
            if (pair_ev)
                locked_q <= 1'b1;
        end
    end

    assign sample_valid = valid_q;
    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign locked       = locked_q;
    assign overflow     = overflow_q;
    assign short_err    = short_q;

`ifdef I2S_CAPTURE_PEAK_EN
    logic [WIDTH-2:0] peak_l_q, peak_r_q, mag_l, mag_r;

    // Two's-complement magnitude; the most negative code saturates to full scale.
    function automatic logic [WIDTH-2:0] magnitude(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] neg;
        neg = -w;
        if (!w[WIDTH-1])
            return w[WIDTH-2:0];
        if (neg[WIDTH-1])
            return '1;
        return neg[WIDTH-2:0];
    endfunction

    assign mag_l = magnitude(left_hold_q);
    assign mag_r = magnitude(shreg_q);

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else if (peak_clr) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else if (load) begin
            if (mag_l > peak_l_q)
                peak_l_q <= mag_l;
            if (mag_r > peak_r_q)
                peak_r_q <= mag_r;
        end
    end

    assign peak_l = peak_l_q;
    assign peak_r = peak_r_q;
`endif

endmodule

// File: tb/tb_i2s_frame_capture.sv
// Bench for i2s_frame_capture: table of framed L/R vectors, hand-written corner sequences,
// then randomised frames checked against a word-level pairing model and scoreboard.
`timescale 1ns/1ps
module tb_i2s_frame_capture;

    logic        clk_in = 1'b0;
    logic        resetb = 1'b0;
    logic        i2s_bck = 1'b0;
    logic        i2s_ws = 1'b0;
    logic        i2s_d0 = 1'b0;
    logic        sample_ready = 1'b0;
    logic        sample_valid;
    logic [23:0] sample_l, sample_r;
    logic        locked, overflow, short_err;
`ifdef I2S_CAPTURE_PEAK_EN
    logic        peak_clr = 1'b0;
    logic [22:0] peak_l, peak_r;
`endif

    i2s_frame_capture dut (
        .clk_in       (clk_in),
        .resetb       (resetb),
        .i2s_bck      (i2s_bck),
        .i2s_ws       (i2s_ws),
        .i2s_d0       (i2s_d0),
        .sample_ready (sample_ready),
`ifdef I2S_CAPTURE_PEAK_EN
        .peak_clr     (peak_clr),
        .peak_l       (peak_l),
        .peak_r       (peak_r),
`endif
        .sample_valid (sample_valid),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .locked       (locked),
        .overflow     (overflow),
        .short_err    (short_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] ld;
        int          lb;
        logic [31:0] rd;
        int          rb;
        int          exp_pairs;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
        int          exp_short;
    } vec_t;

    localparam logic [31:0] CLOSE_L = 32'h5A5A5A00;

    vec_t        tbl[7];
    int          total = 0, bad = 0;
    int          n_pair = 0, n_short = 0, n_ovf = 0;
    logic [23:0] last_l = '0, last_r = '0;
    bit          sb_on = 1'b0, rand_mode = 1'b0;
    logic        ready_fixed = 1'b1;
    logic [47:0] exp_q[$];
    logic [47:0] sb_e;
    logic [23:0] m_left;
    bit          m_have_left;
    int          m_short;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic ws, input logic d);
        @(negedge clk_in);
        i2s_bck = 1'b0;
        i2s_ws  = ws;
        i2s_d0  = d;
        repeat (4) @(negedge clk_in);
        i2s_bck = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    // Sends slot bits [from, to) of an MSB-aligned 32-bit slot image.
    task automatic send_bits(input logic ws, input logic [31:0] data, input int from, input int to);
        for (int i = from; i < to; i++)
            send_bit(ws, data[31-i]);
    endtask

    // Word-level reference: what happens to each completed slot once the capture is synchronised.
    task automatic model_word(input bit ws, input int nb, input logic [31:0] d);
        if (nb < 16) begin
            m_short++;
            m_have_left = 1'b0;
        end else if (!ws) begin
            m_have_left = 1'b1;
            m_left      = d[31:8];
        end else if (m_have_left) begin
            exp_q.push_back({m_left, d[31:8]});
            m_have_left = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            #2;
            sample_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    always @(negedge clk_in) begin
        if (resetb) begin
            if (short_err) n_short++;
            if (overflow)  n_ovf++;
            if (sample_valid && sample_ready) begin
                n_pair++;
                last_l = sample_l;
                last_r = sample_r;
                $display("pair %0d: L=%06h R=%06h", n_pair, sample_l, sample_r);
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_extra_pair", 32'd1, 32'd0);
                    end else begin
                        sb_e = exp_q.pop_front();
                        chk("sb_l", sample_l, sb_e[47:24]);
                        chk("sb_r", sample_r, sb_e[23:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp, ss, so, nb;
        logic [31:0] d;
        logic [31:0] ones;
        ones = '1;

        tbl[0] = '{32'h12345600, 32, 32'hABCDEF00, 32, 1, 24'h123456, 24'hABCDEF, 0};
        tbl[1] = '{32'hFFFFF000, 20, 32'h12345000, 20, 1, 24'hFFFFF0, 24'h123450, 0};
        tbl[2] = '{32'hABC00000, 12, 32'h11223300, 24, 0, 24'h0,      24'h0,      1};
        tbl[3] = '{32'hABCD0000, 16, 32'h80010000, 16, 1, 24'hABCD00, 24'h800100, 0};
        tbl[4] = '{32'h55AA5500, 24, 32'h7FFE0000, 15, 0, 24'h0,      24'h0,      1};
        tbl[5] = '{32'hC0FFEE00, 24, 32'h0BADF000, 24, 1, 24'hC0FFEE, 24'h0BADF0, 0};
        tbl[6] = '{32'h876543F0, 28, 32'h00000100, 24, 1, 24'h876543, 24'h000001, 0};

        repeat (3) @(negedge clk_in);
        chk("rst_valid", sample_valid, 0);
        chk("rst_l", sample_l, 0);
        chk("rst_r", sample_r, 0);
        chk("rst_locked", locked, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_short", short_err, 0);
        resetb = 1'b1;

        // Priming right slot gives the first boundary, which only synchronises.
        send_bits(1'b1, 32'hFFFFFF00, 0, 24);
        sp = 0; ss = 0;
        for (int i = 0; i <= 7; i++) begin
            d = (i < 7) ? tbl[i].ld : CLOSE_L;
            send_bits(1'b0, d, 0, 1);
            if (i > 0) begin
                $display("vec %0d: pairs=%0d shorts=%0d L=%06h R=%06h",
                         i - 1, n_pair - sp, n_short - ss, last_l, last_r);
                chk($sformatf("vec%0d_pairs", i - 1), n_pair - sp, tbl[i-1].exp_pairs);
                chk($sformatf("vec%0d_shorts", i - 1), n_short - ss, tbl[i-1].exp_short);
                if (tbl[i-1].exp_pairs != 0) begin
                    chk($sformatf("vec%0d_l", i - 1), last_l, tbl[i-1].exp_l);
                    chk($sformatf("vec%0d_r", i - 1), last_r, tbl[i-1].exp_r);
                end
            end
            sp = n_pair;
            ss = n_short;
            if (i < 7) begin
                send_bits(1'b0, tbl[i].ld, 1, tbl[i].lb);
                send_bits(1'b1, tbl[i].rd, 0, tbl[i].rb);
            end
        end
        chk("table_overflow", n_ovf, 0);
        chk("table_locked", locked, 1);

        // Back-pressure across two frames: first pair held, second dropped.
        ready_fixed = 1'b0;
        sp = n_pair; so = n_ovf;
        send_bits(1'b0, CLOSE_L, 1, 32);
        send_bits(1'b1, 32'h13579B00, 0, 32);
        send_bits(1'b0, 32'h2468AC00, 0, 1);
        chk("bp_valid1", sample_valid, 1);
        chk("bp_l1", sample_l, 24'h5A5A5A);
        chk("bp_r1", sample_r, 24'h13579B);
        send_bits(1'b0, 32'h2468AC00, 1, 32);
        send_bits(1'b1, 32'hFEDCBA00, 0, 32);
        send_bits(1'b0, 32'h0F0F0F00, 0, 1);
        $display("backpressure: overflow pulses=%0d", n_ovf - so);
        chk("bp_overflow", n_ovf - so, 1);
        chk("bp_valid2", sample_valid, 1);
        chk("bp_l2", sample_l, 24'h5A5A5A);
        chk("bp_r2", sample_r, 24'h13579B);
        ready_fixed = 1'b1;
        repeat (4) @(negedge clk_in);
        chk("bp_valid_low", sample_valid, 0);
        chk("bp_transfers", n_pair - sp, 1);
        chk("bp_xfer_l", last_l, 24'h5A5A5A);

        // Stop bck long enough to drop lock.
        ready_fixed = 1'b0;
        @(negedge clk_in);
        i2s_bck = 1'b0;
        repeat (300) @(negedge clk_in);
        $display("timeout: locked=%0d", locked);
        chk("tmo_locked", locked, 0);
        send_bits(1'b0, 32'h11111100, 0, 24);
        send_bits(1'b1, 32'h22222200, 0, 24);
        send_bits(1'b0, 32'h3C3C3C00, 0, 24);
        send_bits(1'b1, 32'hC3C3C300, 0, 24);
        chk("tmo_no_pair_yet", sample_valid, 0);
        send_bits(1'b0, 32'h0F0F0F00, 0, 1);
        chk("tmo_valid", sample_valid, 1);
        chk("tmo_l", sample_l, 24'h3C3C3C);
        chk("tmo_r", sample_r, 24'hC3C3C3);
        chk("tmo_relocked", locked, 1);

        // Reset during bit 10 of a left word while a pair is presented.
        send_bits(1'b0, 32'h0F0F0F00, 1, 10);
        @(negedge clk_in);
        i2s_bck = 1'b0;
        repeat (2) @(negedge clk_in);
        resetb = 1'b0;
        #1;
        $display("midreset: valid=%0d locked=%0d", sample_valid, locked);
        chk("mr_valid", sample_valid, 0);
        chk("mr_l", sample_l, 0);
        chk("mr_r", sample_r, 0);
        chk("mr_locked", locked, 0);
        repeat (3) @(negedge clk_in);
        resetb = 1'b1;
        ready_fixed = 1'b1;
        send_bits(1'b0, 32'h0F0F0F00, 11, 32);
        send_bits(1'b1, 32'h22222200, 0, 24);
        sp = n_pair;
        send_bits(1'b0, 32'h600DF000, 0, 24);
        send_bits(1'b1, 32'hBEEF0100, 0, 24);
        chk("mr_no_pair_yet", n_pair - sp, 0);
        send_bits(1'b0, CLOSE_L, 0, 1);
        chk("mr_pairs", n_pair - sp, 1);
        chk("mr_pair_l", last_l, 24'h600DF0);
        chk("mr_pair_r", last_r, 24'hBEEF01);

        // Randomised frames against the word-level model.
        @(negedge clk_in);
        resetb = 1'b0;
        repeat (3) @(negedge clk_in);
        resetb = 1'b1;
        i2s_bck = 1'b0;
        m_have_left = 1'b0;
        m_short = 0;
        ss = n_short; so = n_ovf;
        sb_on = 1'b1;
        rand_mode = 1'b1;
        send_bits(1'b1, 32'hFFFFFF00, 0, 24);
        for (int k = 0; k < 40; k++) begin
            nb = $urandom_range(10, 32);
            d  = $urandom() & ~(ones >> nb);
            send_bits((k % 2) != 0, d, 0, nb);
            model_word((k % 2) != 0, nb, d);
        end
        send_bits(1'b0, 32'h80000000, 0, 1);
        for (int w = 0; w < 60 && exp_q.size() != 0; w++)
            @(negedge clk_in);
        $display("random: shorts=%0d model_shorts=%0d pending=%0d", n_short - ss, m_short, exp_q.size());
        chk("sb_drain", exp_q.size(), 0);
        chk("rand_shorts", n_short - ss, m_short);
        chk("rand_overflow", n_ovf - so, 0);
        sb_on = 1'b0;
        rand_mode = 1'b0;
        ready_fixed = 1'b1;

`ifdef I2S_CAPTURE_PEAK_EN
        @(negedge clk_in);
        peak_clr = 1'b1;
        @(negedge clk_in);
        peak_clr = 1'b0;
        chk("peak_clr_l0", peak_l, 0);
        chk("peak_clr_r0", peak_r, 0);
        send_bits(1'b0, 32'h80000000, 1, 32);
        send_bits(1'b1, 32'h00001000, 0, 32);
        send_bits(1'b0, 32'h00000000, 0, 1);
        $display("peak: L=%06h R=%06h", peak_l, peak_r);
        chk("peak_l", peak_l, 23'h7FFFFF);
        chk("peak_r", peak_r, 23'h000010);
        @(negedge clk_in);
        peak_clr = 1'b1;
        @(negedge clk_in);
        peak_clr = 1'b0;
        chk("peak_clr_l", peak_l, 0);
        chk("peak_clr_r", peak_r, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_frame_capture.md
# i2s_frame_capture

Downstream consumer of the S/PDIF decoder's I2S outputs. Oversamples `i2s_bck`, `i2s_ws` and `i2s_d0` on the system clock and deserialises each channel word. Pairs left and right words into one stereo sample and hands the pair to the audio sink over a valid/ready handshake. Also reports lock state and dropped samples.

## Interface
- `WIDTH`, 24: captured word width in bits (MSB first).
- `MIN_BITS`, 16: a word with fewer bits than this is discarded as short.
- `TIMEOUT`, 255: system clocks without a `bck` rising edge before lock is dropped (8-bit counter).
- `clk_in`  in  1  system clock.
- `resetb`  in  1  asynchronous active-low reset.
- `i2s_bck`  in  1  bit clock, asynchronous to `clk_in`.
- `i2s_ws`  in  1  word select: 0 = left, 1 = right.
- `i2s_d0`  in  1  serial data.
- `sample_ready`  in  1  sink accepts the pair.
- `sample_valid`  out  1  a pair is presented.
- `sample_l`  out  WIDTH  left word.
- `sample_r`  out  WIDTH  right word.
- `locked`  out  1  at least one pair captured and `bck` is active.
- `overflow`  out  1  one-cycle pulse when a completed pair is dropped.
- `short_err`  out  1  one-cycle pulse when a word shorter than `MIN_BITS` is discarded.

## Operation
- Input conditioning:
  - Each input passes through a 2-flop synchroniser, then one history register.
  - A `bck` rising edge (`rise`) is history 0 and synchronised 1.
  - `ws`/`d0` are sampled from the synchronised stage on `rise`.
- Bit counter `cnt` (6 bits):
  - Saturates at 63.
  - On each `rise` with no boundary, if `cnt < WIDTH` then `shreg[WIDTH-1-cnt] <= d0`; `cnt` increments.
  - Bits beyond `WIDTH` are ignored.
  - Unwritten LSBs stay 0, so short-but-valid words are MSB-aligned and zero-padded.
- Boundary:
  - A boundary is a `rise` where the sampled `ws` differs from the `ws` stored at the previous `rise`.
  - The bit sampled on the boundary `rise` is bit 0 (MSB) of the new word (left-justified framing).
  - On a boundary, the previous word (`shreg`, `cnt`) is completed and tagged with the old `ws`.
  - Then `shreg` is cleared except for the new MSB, and `cnt <= 1`.
- Word acceptance: a completed word with `cnt < MIN_BITS` pulses `short_err` and is discarded.
- FSM states:
  - HUNT: after reset or timeout. The first boundary moves to WAIT_L; the partial word before it is discarded.
  - WAIT_L: wait for a completed left word (old `ws`=0). Once accepted, store it in `left_hold` and go to WAIT_R. A completed right word here is discarded and the state stays WAIT_L.
  - WAIT_R:
    - A completed right word forms the pair `{left_hold, word}` and goes to WAIT_L.
    - A completed left word instead replaces `left_hold`; the state stays WAIT_R.
    - A short word returns to WAIT_L.
- Output handshake:
  - When a pair forms and `sample_valid`=0 or (`sample_valid` and `sample_ready`), load `sample_l`/`sample_r`; `sample_valid` = 1.
  - If `sample_valid`=1 and `sample_ready`=0, drop the new pair, pulse `overflow`, and keep the presented data unchanged.
  - Transfer completes on a cycle with `sample_valid` and `sample_ready`. `sample_valid` drops the next cycle unless a new pair loads simultaneously.
  - Data is stable while `sample_valid` is high and `sample_ready` is low.
- Lock:
  - `locked` is set when the first pair forms.
  - The timeout counter resets on each `rise` and saturates at `TIMEOUT`.
  - Reaching `TIMEOUT`: `locked`=0 and FSM goes to HUNT. `cnt` is cleared and `left_hold` discarded. A presented pair stays until accepted.
- Reset (asynchronous, any time):
  - All outputs 0, including `sample_l`/`sample_r`.
  - FSM in HUNT, all counters and synchronisers 0.

## Timing
- Pin-to-`rise` latency: 3 `clk_in` cycles.
- Boundary `rise` cycle → `sample_valid` high on the next clock edge. Same cycle for `short_err`/`overflow` pulses.
- Minimum supported `bck` high/low time: 3 `clk_in` cycles.
- Simultaneous pair formation and handshake completion: the new pair loads and `sample_valid` stays 1, with no `overflow`.
- Timeout and boundary in the same cycle: timeout wins.

## Configuration
- `I2S_CAPTURE_PEAK_EN`
  - Defined:
    - Adds input `peak_clr` and outputs `peak_l`, `peak_r` (WIDTH-1 bits each).
    - On each loaded pair, each peak takes the max of itself and the magnitude of the two's-complement word. The most negative value saturates to 2^(WIDTH-1)-1.
    - `peak_clr` high zeroes both peaks and overrides an update in the same cycle.
    - Reset value 0.
  - Undefined: the ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset mid-frame: assert `resetb`=0 during bit 10 of a left word → all outputs 0 immediately; after release, the first boundary is discarded and no pair appears until a full L then R is seen.
- Nominal 32-bit slots, L=0x123456, R=0xABCDEF (padded with 8 zero bits) → one pair `sample_l`=0x123456, `sample_r`=0xABCDEF, `sample_valid`=1 one clock after the R→L boundary `rise`; `locked`=1.
- 20-bit slots with L=0xFFFFF → `sample_l`=0xFFFFF0 (zero-padded LSBs); 12-bit slot → `short_err` pulse and no pair.
- Hold `sample_ready`=0 across two frames → first pair stays unchanged, one `overflow` pulse for the second; assert ready → transfer, `sample_valid` low next cycle.
- Stop `bck` for 256 clocks → `locked`=0 and FSM in HUNT; restarting `bck` needs a boundary plus a full L/R before `sample_valid`.
- With `I2S_CAPTURE_PEAK_EN`: L=0x800000, R=0x000010 → `peak_l`=0x7FFFFF, `peak_r`=0x000010; `peak_clr` pulse → both 0.
